// File: rtl/nn_ctrl_pkg.sv
// rtl/nn_ctrl_pkg.sv - shared constants and FSM encoding for the relu_nn inference controller
package nn_ctrl_pkg;

  localparam int NUM_WREGS = 9;

  localparam logic [3:0] ADDR_H1_W1    = 4'd0;
  localparam logic [3:0] ADDR_H1_W2    = 4'd1;
  localparam logic [3:0] ADDR_H1_BIAS  = 4'd2;
  localparam logic [3:0] ADDR_H2_W1    = 4'd3;
  localparam logic [3:0] ADDR_H2_W2    = 4'd4;
  localparam logic [3:0] ADDR_H2_BIAS  = 4'd5;
  localparam logic [3:0] ADDR_OUT_W1   = 4'd6;
  localparam logic [3:0] ADDR_OUT_W2   = 4'd7;
  localparam logic [3:0] ADDR_OUT_BIAS = 4'd8;

  localparam logic [15:0] ONE  = 16'h0100;
  localparam logic [15:0] HALF = 16'h0080;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nn_weight_regfile.sv
// rtl/nn_weight_regfile.sv - nine weight/bias registers with a packed read bus
module nn_weight_regfile
  import nn_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [3:0]                 addr,
  input  logic [WIDTH-1:0]           wdata,
  output logic [NUM_WREGS*WIDTH-1:0] w_bus,
  output logic                       addr_err
);

  logic [WIDTH-1:0] regs [NUM_WREGS];

  assign addr_err = (addr >= 4'(NUM_WREGS));

  // Out-of-range addresses match no entry, so they fall through without a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_WREGS; i++) begin
        if (we && (addr == 4'(i))) regs[i] <= wdata;
      end
    end
  end

  for (genvar g = 0; g < NUM_WREGS; g++) begin : g_pack
    assign w_bus[g*WIDTH +: WIDTH] = regs[g];
  end

endmodule

// File: rtl/relu_nn.sv
// rtl/relu_nn.sv - six-stage pipelined 2-2-1 ReLU network in signed fixed point
module relu_nn #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     net_input1,
  input  logic [WIDTH-1:0]     net_input2,
  input  logic [9*WIDTH-1:0]   weights,
  output logic [WIDTH-1:0]     net_output
);

  localparam int PW = 2*WIDTH;

  logic signed [WIDTH-1:0] w [9];
  logic signed [WIDTH-1:0] x1, x2;
  logic signed [PW-1:0]    p11, p12, p21, p22, q1, q2;
  logic signed [PW:0]      s1, s2, so;
  logic signed [WIDTH-1:0] a1, a2, h1, h2, y;

  always_comb begin
    for (int i = 0; i < 9; i++) w[i] = weights[i*WIDTH +: WIDTH];
  end

  assign x1 = net_input1;
  assign x2 = net_input2;
  assign so = {q1[PW-1], q1} + {q2[PW-1], q2};
  assign net_output = y;

  // Stages: products, sums, rescale+bias, relu, output products, output sum+bias.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p11 <= '0; p12 <= '0; p21 <= '0; p22 <= '0;
      s1  <= '0; s2  <= '0;
      a1  <= '0; a2  <= '0;
      h1  <= '0; h2  <= '0;
      q1  <= '0; q2  <= '0;
      y   <= '0;
    end else begin
      p11 <= x1 * w[0];
      p12 <= x2 * w[1];
      p21 <= x1 * w[3];
      p22 <= x2 * w[4];
      s1  <= {p11[PW-1], p11} + {p12[PW-1], p12};
      s2  <= {p21[PW-1], p21} + {p22[PW-1], p22};
      a1  <= s1[FRAC +: WIDTH] + w[2];
      a2  <= s2[FRAC +: WIDTH] + w[5];
      h1  <= a1[WIDTH-1] ? '0 : a1;
      h2  <= a2[WIDTH-1] ? '0 : a2;
      q1  <= h1 * w[6];
      q2  <= h2 * w[7];
      y   <= so[FRAC +: WIDTH] + w[8];
    end
  end

endmodule

// File: rtl/nn_infer_ctrl.sv
// rtl/nn_infer_ctrl.sv - weight config, input handshake and result capture around one relu_nn
module nn_infer_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter int               FRAC       = 8,
  parameter int               NN_LATENCY = 6,
  parameter logic [WIDTH-1:0] THRESH     = WIDTH'(1) << (FRAC - 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [3:0]                 cfg_addr,
  input  logic [WIDTH-1:0]           cfg_wdata,
  output logic                       cfg_ready,
  output logic                       cfg_err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_x1,
  input  logic [WIDTH-1:0]           in_x2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_bit,
  output logic                       busy,
  output logic [WIDTH-1:0]           nn_x1,
  output logic [WIDTH-1:0]           nn_x2,
  output logic [NUM_WREGS*WIDTH-1:0] nn_w,
  input  logic [WIDTH-1:0]           nn_y
);

  localparam int CNT_W = $clog2(NN_LATENCY + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             idle, accept, capture, addr_err;

  assign idle      = (state == ST_IDLE);
  assign in_ready  = idle;
  assign cfg_ready = idle;
  assign busy      = !idle;
  assign accept    = in_valid && idle;

  // Writes only land in IDLE, which keeps weights frozen across an inference.
  nn_weight_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (cfg_we && idle),
    .addr     (cfg_addr),
    .wdata    (cfg_wdata),
    .w_bus    (nn_w),
    .addr_err (addr_err)
  );

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (cnt == CNT_W'(NN_LATENCY)) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      nn_x1     <= '0;
      nn_x2     <= '0;
      out_data  <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (!idle || addr_err);
      if (accept) begin
        nn_x1 <= in_x1;
        nn_x2 <= in_x2;
        cnt   <= '0;
      end else if (state == ST_WAIT && cnt != CNT_W'(NN_LATENCY)) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (capture) begin
        out_data  <= nn_y;
        out_bit   <= ($signed(nn_y) > $signed(THRESH));
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nn_infer_ctrl.sv
// tb/tb_nn_infer_ctrl.sv - directed self-checking bench for nn_infer_ctrl driving relu_nn
module tb_nn_infer_ctrl;
  import nn_ctrl_pkg::*;

  logic         clk, rst;
  logic         cfg_we, cfg_ready, cfg_err;
  logic [3:0]   cfg_addr;
  logic [15:0]  cfg_wdata;
  logic         in_valid, in_ready, out_valid, out_ready, out_bit, busy;
  logic [15:0]  in_x1, in_x2, out_data, nn_x1, nn_x2, nn_y;
  logic [143:0] nn_w;

  int n_checks = 0;
  int n_fail   = 0;

  nn_infer_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bit(out_bit),
    .busy(busy), .nn_x1(nn_x1), .nn_x2(nn_x2), .nn_w(nn_w), .nn_y(nn_y)
  );

  relu_nn u_nn (
    .clk(clk), .rst(rst),
    .net_input1(nn_x1), .net_input2(nn_x2), .weights(nn_w), .net_output(nn_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] neuron(input longint a, input longint b,
                                         input logic [15:0] bias, input bit do_relu);
    longint s;
    logic [15:0] t;
    s = (a + b) >>> 8;
    t = s[15:0];
    t = t + bias;
    if (do_relu && t[15]) t = 16'h0000;
    return t;
  endfunction

  function automatic logic [15:0] golden(input logic [143:0] w, input logic [15:0] x1,
                                         input logic [15:0] x2);
    longint sw [9];
    longint a, b;
    logic [15:0] h1, h2;
    logic [15:0] tmp;
    for (int i = 0; i < 9; i++) begin
      tmp = w[i*16 +: 16];
      sw[i] = longint'($signed(tmp));
    end
    a = longint'($signed(x1));
    b = longint'($signed(x2));
    h1 = neuron(a*sw[0], b*sw[1], w[2*16 +: 16], 1'b1);
    h2 = neuron(a*sw[3], b*sw[4], w[5*16 +: 16], 1'b1);
    return neuron(longint'($signed(h1))*sw[6], longint'($signed(h2))*sw[7], w[8*16 +: 16], 1'b0);
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    @(posedge clk); #1 cfg_we = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns cycles from accept edge to out_valid (0 = timed out).
  task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b,
                                output int lat, output int ir_bad);
    in_x1 = a; in_x2 = b; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; cfg_we = 1'b0;
    lat = 0; ir_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) begin lat = k; break; end
      if (in_ready) ir_bad++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int seen;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (nn_w !== 144'h0) begin n_fail++; $display("FAIL reset_nn_w got=%h exp=0", nn_w); end
    n_checks++; if ({nn_x1, nn_x2, out_data} !== 48'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", {nn_x1, nn_x2, out_data}); end
    rst = 1'b1;
    @(negedge clk);
    cfg_write(ADDR_H1_W1, ONE);
    in_x1 = ONE; in_x2 = ONE; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midwait_busy got=%b exp=1", busy); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (nn_w !== 144'h0) begin n_fail++; $display("FAIL midreset_nn_w got=%h exp=0", nn_w); end
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abandoned_result got=%0d exp=0", seen); end
  endtask

  task automatic test_xor();
    logic [15:0] wv [9];
    logic [15:0] xa [4];
    logic [15:0] xb [4];
    logic [15:0] ed [4];
    logic        eb [4];
    int lat, ir_bad;
    wv = '{16'h00D3, 16'hFF0D, 16'h0000, 16'hFF2D, 16'h00F3, 16'h0000, 16'h0133, 16'h0100, 16'h0000};
    xa = '{16'h0000, 16'h0000, ONE, ONE};
    xb = '{16'h0000, ONE, 16'h0000, ONE};
    ed = '{16'h0000, 16'h00F3, 16'h00FD, 16'h0020};
    eb = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) cfg_write(4'(i), wv[i]);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (nn_w[i*16 +: 16] !== wv[i]) begin n_fail++; $display("FAIL cfg_w%0d got=%h exp=%h", i, nn_w[i*16 +: 16], wv[i]); end
    end
    for (int v = 0; v < 4; v++) begin
      start_and_wait(xa[v], xb[v], lat, ir_bad);
      n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL latency_%0d got=%0d exp=7", v, lat); end
      n_checks++; if (ir_bad !== 0) begin n_fail++; $display("FAIL in_ready_wait_%0d got=%0d exp=0", v, ir_bad); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL in_ready_done_%0d got=%b exp=0", v, in_ready); end
      n_checks++; if (out_data !== ed[v]) begin n_fail++; $display("FAIL xor_data_%0d got=%h exp=%h", v, out_data, ed[v]); end
      n_checks++; if (out_data !== golden(nn_w, xa[v], xb[v])) begin n_fail++; $display("FAIL xor_model_%0d got=%h exp=%h", v, out_data, golden(nn_w, xa[v], xb[v])); end
      n_checks++; if (out_bit !== eb[v]) begin n_fail++; $display("FAIL xor_bit_%0d got=%b exp=%b", v, out_bit, eb[v]); end
      consume();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL handshake_%0d got=%b%b exp=01", v, out_valid, in_ready); end
      n_checks++; if (nn_x1 !== xa[v] || nn_x2 !== xb[v]) begin n_fail++; $display("FAIL nn_x_hold_%0d got=%h/%h exp=%h/%h", v, nn_x1, nn_x2, xa[v], xb[v]); end
    end
  endtask

  task automatic test_backpressure();
    int lat, ir_bad, bad;
    logic [15:0] held;
    start_and_wait(ONE, 16'h0000, lat, ir_bad);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL bp_latency got=%0d exp=7", lat); end
    held = out_data;
    n_checks++; if (held !== 16'h00FD) begin n_fail++; $display("FAIL bp_data got=%h exp=00fd", held); end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (!out_valid || out_data !== held || in_ready || !out_bit) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_stable got=%0d bad cycles exp=0", bad); end
    consume();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%b%b exp=01", out_valid, in_ready); end
  endtask

  task automatic test_cfg_guard();
    int lat;
    logic [143:0] saved;
    in_x1 = ONE; in_x2 = 16'h0000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    cfg_addr = ADDR_OUT_W1; cfg_wdata = 16'h0000; cfg_we = 1'b1;
    @(posedge clk); @(negedge clk);
    cfg_we = 1'b0;
    n_checks++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL busy_write_err got=%b%b exp=10", cfg_err, cfg_ready); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_pulse got=%b exp=0", cfg_err); end
    n_checks++; if (nn_w[6*16 +: 16] !== 16'h0133) begin n_fail++; $display("FAIL busy_write_dropped got=%h exp=0133", nn_w[6*16 +: 16]); end
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin lat = 1; break; end
      @(posedge clk); @(negedge clk);
    end
    n_checks++; if (lat !== 1 || out_data !== 16'h00FD) begin n_fail++; $display("FAIL frozen_result got=%h exp=00fd", out_data); end
    consume();
    saved = nn_w;
    cfg_addr = 4'd9; cfg_wdata = 16'h1234; cfg_we = 1'b1;
    @(posedge clk); @(negedge clk);
    cfg_we = 1'b0;
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL addr9_err got=%b exp=1", cfg_err); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (cfg_err !== 1'b0 || nn_w !== saved) begin n_fail++; $display("FAIL addr9_ignored got=%b/%h exp=0/%h", cfg_err, nn_w, saved); end
  endtask

  task automatic test_simultaneous();
    int lat, ir_bad;
    cfg_addr = ADDR_OUT_W1; cfg_wdata = 16'h0000; cfg_we = 1'b1;
    start_and_wait(ONE, 16'h0000, lat, ir_bad);
    n_checks++; if (nn_w[6*16 +: 16] !== 16'h0000) begin n_fail++; $display("FAIL simul_weight got=%h exp=0000", nn_w[6*16 +: 16]); end
    n_checks++; if (lat !== 7 || cfg_err !== 1'b0) begin n_fail++; $display("FAIL simul_latency got=%0d/%b exp=7/0", lat, cfg_err); end
    n_checks++; if (out_data !== 16'h0000 || out_bit !== 1'b0) begin n_fail++; $display("FAIL simul_result got=%h/%b exp=0000/0", out_data, out_bit); end
    n_checks++; if (out_data !== golden(nn_w, ONE, 16'h0000)) begin n_fail++; $display("FAIL simul_model got=%h exp=%h", out_data, golden(nn_w, ONE, 16'h0000)); end
    consume();
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_x1 = '0; in_x2 = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_xor();
    test_backpressure();
    test_cfg_guard();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
